// File: rtl/jpeg_pkg.sv
// Shared widths, types and the output clamp for the JPEG dequantizer.
package jpeg_pkg;

    localparam int unsigned BLOCK_SIZE = 64;
    localparam int unsigned CW = 12;
    localparam int unsigned QW = 8;
    localparam int unsigned OW = 16;
    localparam int unsigned PW = CW + QW + 1;

    typedef logic signed [CW-1:0] coef_t;
    typedef logic        [QW-1:0] qval_t;

    // In range when every bit from the OW-1 sign position up matches the MSB.
    function automatic logic signed [OW-1:0] sat_ow(input logic signed [PW-1:0] v);
        if (v[PW-1:OW-1] == {(PW-OW+1){v[PW-1]}}) begin
            return v[OW-1:0];
        end else if (v[PW-1]) begin
            return {1'b1, {(OW-1){1'b0}}};
        end else begin
            return {1'b0, {(OW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/jpeg_qtable.sv
// 64-entry quantization table: async reset to all ones, one write port,
// one registered read port that only advances when the pipeline does.
module jpeg_qtable
    import jpeg_pkg::*;
#(
    parameter int unsigned QW = jpeg_pkg::QW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [5:0]    waddr_i,
    input  logic [QW-1:0] wdata_i,
    input  logic [5:0]    raddr_i,
    output logic [QW-1:0] rdata_o
);

    logic [QW-1:0] mem_q [BLOCK_SIZE];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem_q[i] <= QW'(1);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-edge write to the read address returns the old entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (en_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/jpeg_dequant.sv
// Streaming JPEG dequantizer: coefficient * table[zigzag index], saturated,
// through a two-stage pipeline sharing one enable.
module jpeg_dequant
    import jpeg_pkg::*;
#(
    parameter int unsigned CW = jpeg_pkg::CW,
    parameter int unsigned QW = jpeg_pkg::QW,
    parameter int unsigned OW = jpeg_pkg::OW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 tbl_we_i,
    input  logic [5:0]           tbl_addr_i,
    input  logic [QW-1:0]        tbl_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [CW-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [OW-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int unsigned ProdW = CW + QW + 1;

    logic                    en;
    logic                    xfer;
    logic [5:0]              idx_q;
    logic signed [CW-1:0]    s1_coef_q;
    logic [QW-1:0]           s1_qval;
    logic                    s1_last_q;
    logic                    s1_valid_q;
    logic signed [ProdW-1:0] prod;
    logic signed [OW-1:0]    prod_sat;

    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;
    assign xfer       = in_valid_i && en;
    assign busy_o     = (idx_q != '0) || s1_valid_q || out_valid_o;

    jpeg_qtable #(
        .QW(QW)
    ) u_qtable (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en),
        .we_i   (tbl_we_i),
        .waddr_i(tbl_addr_i),
        .wdata_i(tbl_data_i),
        .raddr_i(idx_q),
        .rdata_o(s1_qval)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (clear_i) begin
            idx_q <= '0;
        end else if (xfer) begin
            idx_q <= idx_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_coef_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_valid_q <= 1'b0;
        end else if (clear_i) begin
            s1_valid_q <= 1'b0;
        end else if (en) begin
            s1_coef_q  <= in_data_i;
            s1_last_q  <= (idx_q == 6'd63);
            s1_valid_q <= xfer;
        end
    end

    // Zero-extend the table value so it multiplies as unsigned.
    assign prod = $signed(s1_coef_q) * $signed({1'b0, s1_qval});

    if (CW == jpeg_pkg::CW && QW == jpeg_pkg::QW && OW == jpeg_pkg::OW) begin : g_pkg_sat
        assign prod_sat = sat_ow(prod);
    end else begin : g_gen_sat
        always_comb begin
            prod_sat = prod[OW-1:0];
            if (prod[ProdW-1:OW-1] != {(ProdW-OW+1){prod[ProdW-1]}}) begin
                prod_sat = prod[ProdW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (clear_i) begin
            out_valid_o <= 1'b0;
        end else if (en) begin
            out_data_o  <= prod_sat;
            out_last_o  <= s1_last_q;
            out_valid_o <= s1_valid_q;
        end
    end

endmodule

// File: tb/tb_jpeg_dequant.sv
// Scoreboard bench for jpeg_dequant: driver pushes expected results, a
// negedge monitor pops and compares on every output handshake.
module tb_jpeg_dequant;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic               tbl_we = 1'b0;
    logic [5:0]         tbl_addr = '0;
    logic [7:0]         tbl_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [11:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               out_last;
    logic               busy;
    logic               rnd_ready = 1'b0;

    typedef struct packed {
        logic signed [15:0] d;
        logic               l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    jpeg_dequant u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .tbl_we_i   (tbl_we),
        .tbl_addr_i (tbl_addr),
        .tbl_data_i (tbl_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake compare, stall stability, stalled-input check.
    initial begin
        logic               prev_stall;
        logic signed [15:0] prev_d;
        logic               prev_l;
        exp_t               e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && out_valid) begin
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (out_valid && !out_ready) chk("in_ready_when_stalled", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                end
            end
        end
    end

    task automatic send(input int c, input int e, input bit l);
        exp_t x;
        bit   got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data = 12'(c);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.d = 16'(e);
                x.l = l;
                sb.push_back(x);
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("send_accepted", got, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic twrite(input int a, input int v);
        tbl_we = 1'b1;
        tbl_addr = 6'(a);
        tbl_data = 8'(v);
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Clear with a simultaneous input that must be dropped.
    task automatic do_clear();
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 12'sd5;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pass-through block.
        for (int n = 0; n < 64; n++) send(n - 32, n - 32, n == 63);
        drain();

        for (int k = 0; k < 64; k++) twrite(k, k + 1);
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 64; k++) send(3, 3 * (k + 1), k == 63);
        drain();

        // Random backpressure over three blocks.
        rnd_ready = 1'b1;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 64; k++) send(k - 20, (k - 20) * (k + 1), k == 63);
        rnd_ready = 1'b0;
        drain();

        // Table write colliding with the stage-1 read of index 5.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) begin
                if (b == 0 && k == 5) begin
                    tbl_we = 1'b1;
                    tbl_addr = 6'd5;
                    tbl_data = 8'd100;
                end
                send(3, (b == 1 && k == 5) ? 300 : 3 * (k + 1), k == 63);
                tbl_we = 1'b0;
            end
        end
        drain();

        // Saturation and zero table entry at index 0.
        do_clear();
        twrite(0, 255);
        send(2047, 32767, 1'b0);
        @(negedge clk);
        chk("latency_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("latency_cycle2_valid", out_valid, 1);
        @(posedge clk);
        #1;
        drain();
        do_clear();
        send(-2048, -32768, 1'b0);
        drain();
        do_clear();
        send(-1, -255, 1'b0);
        drain();
        do_clear();
        twrite(0, 0);
        send(1234, 0, 1'b0);
        drain();
        do_clear();
        twrite(0, 1);

        // Mid-block clear after 10 transfers.
        for (int k = 0; k < 10; k++) send(1, (k == 5) ? 100 : k + 1, 1'b0);
        do_clear();
        @(negedge clk);
        chk("clear_out_valid", out_valid, 0);
        chk("clear_busy", busy, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) send(1, (k == 5) ? 100 : k + 1, k == 63);
        drain();

        // Reset mid-stream restores pass-through table.
        for (int k = 0; k < 10; k++) send(2, (k == 5) ? 200 : 2 * (k + 1), 1'b0);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send(7, 7, 1'b0);
        drain();

        chk("sb_empty_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_dequant.md
Name: jpeg_dequant

Overview:
- Streaming dequantizer for the JPEG decode/verify path; the inverse of the encoder's reciprocal-multiply quantizer.
- Takes quantized coefficients in zigzag order, 64 per block.
- Multiplies each coefficient by the matching entry of a programmable 64-entry quantization table.
- Emits saturated 16-bit coefficients toward the IDCT, with valid/ready flow control on both sides.

Parameters:
- CW, 12, width of the signed quantized input coefficient.
- QW, 8, width of the unsigned quantization table entry.
- OW, 16, width of the signed output coefficient.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous; resets the block index and flushes the pipeline.
- tbl_we_i  in  1  quantization table write strobe.
- tbl_addr_i  in  6  table index (zigzag order).
- tbl_data_i  in  QW  table value.
- in_valid_i  in  1  input coefficient valid.
- in_ready_o  out  1  block accepts the input coefficient this cycle.
- in_data_i  in  CW  signed quantized coefficient.
- out_valid_o  out  1  output coefficient valid.
- out_ready_i  in  1  downstream accepts the output.
- out_data_o  out  OW  signed dequantized coefficient.
- out_last_o  out  1  output is coefficient 63 of the block.
- busy_o  out  1  block index is non-zero, or either pipeline stage holds data.

Behaviour:
- Reset values:
  - All table entries = 1 (pass-through).
  - Index = 0; both stage-valid flags = 0.
  - out_valid_o = 0, out_data_o = 0, out_last_o = 0, busy_o = 0.
- Pipeline is two stages with one global enable: en = !out_valid_o || out_ready_i.
  - in_ready_o = en, a combinational path from out_ready_i.
  - An input transfer occurs when in_valid_i && in_ready_o.
- Stage 1, on en:
  - Registers in_data_i, q = table[index], last = (index == 63), and valid = the transfer flag.
  - The table is read synchronously with the current index.
- Stage 2, on en:
  - Computes product = signed(coef) * unsigned(q), CW+QW+1 bits signed, exact with no rounding.
  - Saturates to [-2^(OW-1), 2^(OW-1)-1].
  - Registers the saturated value into out_data_o; last into out_last_o; valid into out_valid_o.
- Latency:
  - 2 cycles from input transfer to out_valid_o when no stall occurs.
  - While en = 0, both stages hold and the outputs stay stable.
  - Throughput is 1 coefficient per cycle.
- Index counter:
  - Increments on each input transfer.
  - Wraps from 63 to 0, with no gap between blocks.
- clear_i:
  - Index = 0; both stage-valid flags = 0; out_valid_o = 0.
  - Has priority over a simultaneous transfer, which is dropped.
  - Table contents are retained.
- Table write:
  - Takes effect at the clock edge.
  - Accepted at any time, including mid-block.
  - A stage-1 read of the same address in the same cycle returns the old value.
- Table value 0 is legal; the output is 0.
- Saturation boundary, default widths: 2047*255 = 521985 saturates to 32767; -2048*255 saturates to -32768.
- Reset asserted mid-block returns the block to reset state immediately, including the table reset to all 1s.

Decomposition:
- Shared package jpeg_pkg holds:
  - BLOCK_SIZE = 64.
  - Width constants CW, QW, OW.
  - Typedefs coef_t and qval_t.
  - A function sat_ow() that clamps a wide signed value to OW bits.
- Sub-module jpeg_qtable: a 64xQW register file with an async-reset init to 1, one write port, and one synchronous read port gated by en.
- The top level holds the index counter, the pipeline registers and the multiply/saturate logic.

Test Plan:
- Reset release with the table untouched; stream 64 coefficients of value n-32 (n = 0..63) with out_ready_i = 1:
  - out_data_o equals the input, 2 cycles later.
  - out_last_o = 1 only on the 64th output.
- Load table[k] = k+1; input 3 at every index:
  - Outputs are 3, 6, ..., 192.
  - Two back-to-back blocks both give identical output, confirming the wrap from 63 to 0.
- Saturation, with table[0] = 255:
  - Input 2047 -> 32767.
  - Input -2048 -> -32768.
  - Input -1 -> -255.
  - table[0] = 0 with any input -> 0.
- Backpressure:
  - Random out_ready_i (50%) over 3 blocks.
  - No coefficient is lost or duplicated.
  - out_data_o and out_last_o stay stable while out_valid_o && !out_ready_i.
  - in_ready_o = 0 whenever the output is stalled and full.
- Mid-block clear_i after 10 transfers:
  - out_valid_o = 0 in the next cycle; busy_o = 0.
  - The next input uses table[0]; the following out_last_o comes after 64 more transfers.
- Table write to address 5 in the same cycle that index 5 is read:
  - The current output uses the old value.
  - The next block uses the new value.
  - rst_i pulsed mid-stream restores pass-through behaviour.
